// File: rtl/sync_seeker_rr.sv
// sync_seeker_rr
//   Block-sync header seeker. NUM_SEEKERS parallel seekers each scan an equal
//   slice of the FRAME_W candidate offsets for a run of LOCK_CNT consecutive
//   good 2-bit headers (01 or 10). A two-state FSM (SEARCH/LOCKED) takes the
//   first seeker that finds a candidate, picked round-robin after the last
//   winner. While locked it monitors the header at the locked offset and
//   drops lock after UNLOCK_CNT bad headers inside one UNLOCK_WIN-beat window.
//
// Handshake: buf_i is consumed only on cycles with buf_dv_i=1 (a "beat").
//   There is no back-pressure; every beat is accepted. resync_i and the
//   SEARCH->LOCKED transition act on any clock edge, beat or not.
//
// Ports:
//   clk_i, rst_ni  clock, synchronous active-low reset
//   buf_i          presented buffer; header for offset p is buf_i[p+1:p]
//   buf_dv_i       buf_i valid this cycle
//   resync_i       abandon lock (or restart the search)
//   locked_o       lock held at offset_o
//   offset_o       locked offset
//   lock_lost_o    one-cycle pulse on every LOCKED->SEARCH transition
//   winner_o       seeker index that supplied offset_o
//   state_o        FSM state for debug (0=SEARCH, 1=LOCKED)
module sync_seeker_rr #(
    parameter int FRAME_W     = 66,
    parameter int BUF_W       = 194,
    parameter int NUM_SEEKERS = 2,
    parameter int LOCK_CNT    = 32,
    parameter int UNLOCK_CNT  = 16,
    parameter int UNLOCK_WIN  = 64
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [BUF_W-1:0] buf_i,
    input  logic             buf_dv_i,
    input  logic             resync_i,
    output logic             locked_o,
    output logic [6:0]       offset_o,
    output logic             lock_lost_o,
    output logic [((NUM_SEEKERS > 1) ? $clog2(NUM_SEEKERS) : 1)-1:0] winner_o,
    output logic             state_o
);
    localparam int S     = FRAME_W / NUM_SEEKERS;
    localparam int WIN_W = (NUM_SEEKERS > 1) ? $clog2(NUM_SEEKERS) : 1;
    localparam int IDX_W = $clog2(BUF_W);
    localparam int LC_W  = $clog2(LOCK_CNT + 1);
    localparam int BT_W  = $clog2(UNLOCK_WIN + 1);
    localparam int BD_W  = $clog2(UNLOCK_CNT + 1);

    typedef enum logic {SEARCH = 1'b0, LOCKED = 1'b1} state_e;

    state_e            state_q, state_d;
    logic              locked_q, locked_d;
    logic              lock_lost_q, lock_lost_d;
    logic [6:0]        offset_q, offset_d;
    logic [WIN_W-1:0]  winner_q, winner_d;
    logic [WIN_W-1:0]  last_q, last_d;
    logic [BT_W-1:0]   beat_q, beat_d;
    logic [BD_W-1:0]   bad_q, bad_d;
    logic [6:0]        pos_q   [NUM_SEEKERS];
    logic [6:0]        pos_d   [NUM_SEEKERS];
    logic [LC_W-1:0]   cnt_q   [NUM_SEEKERS];
    logic [LC_W-1:0]   cnt_d   [NUM_SEEKERS];
    logic              found_q [NUM_SEEKERS];
    logic              found_d [NUM_SEEKERS];

    logic              hi_v, lo_v, any_found, restart, lock_hdr_good;
    logic [WIN_W-1:0]  sel_hi, sel_lo, sel;
    logic [6:0]        pos_hi, pos_lo, sel_pos;
    logic [BT_W-1:0]   beat_n;
    logic [BD_W-1:0]   bad_n;

    function automatic logic hdr_good(input logic [BUF_W-1:0] b, input logic [6:0] p);
        logic [IDX_W-1:0] i;
        i = IDX_W'(p);
        return b[i + 1'b1] ^ b[i];
    endfunction

    always_comb begin
        state_d     = state_q;
        locked_d    = locked_q;
        lock_lost_d = 1'b0;
        offset_d    = offset_q;
        winner_d    = winner_q;
        last_d      = last_q;
        beat_d      = beat_q;
        bad_d       = bad_q;
        restart     = 1'b0;
        for (int k = 0; k < NUM_SEEKERS; k++) begin
            pos_d[k]   = pos_q[k];
            cnt_d[k]   = cnt_q[k];
            found_d[k] = found_q[k];
        end

        // Round-robin pick: first found seeker above last winner (hi), else
        // the first found seeker at or below it (lo, i.e. after wrapping).
        hi_v   = 1'b0;
        lo_v   = 1'b0;
        sel_hi = '0;
        sel_lo = '0;
        pos_hi = '0;
        pos_lo = '0;
        for (int k = 0; k < NUM_SEEKERS; k++) begin
            if (found_q[k]) begin
                if (WIN_W'(k) > last_q) begin
                    if (!hi_v) begin
                        hi_v   = 1'b1;
                        sel_hi = WIN_W'(k);
                        pos_hi = pos_q[k];
                    end
                end else if (!lo_v) begin
                    lo_v   = 1'b1;
                    sel_lo = WIN_W'(k);
                    pos_lo = pos_q[k];
                end
            end
        end
        any_found = hi_v | lo_v;
        sel       = hi_v ? sel_hi : sel_lo;
        sel_pos   = hi_v ? pos_hi : pos_lo;

        // Monitor counters as they stand after this beat (saturating).
        lock_hdr_good = hdr_good(buf_i, offset_q);
        beat_n = (beat_q == BT_W'(UNLOCK_WIN)) ? beat_q : beat_q + 1'b1;
        bad_n  = (!lock_hdr_good && bad_q != BD_W'(UNLOCK_CNT)) ? bad_q + 1'b1 : bad_q;

        case (state_q)
            SEARCH: begin
                beat_d = '0;
                bad_d  = '0;
                if (resync_i) begin
                    restart = 1'b1;
                end else if (any_found) begin
                    state_d  = LOCKED;
                    locked_d = 1'b1;
                    offset_d = sel_pos;
                    winner_d = sel;
                    last_d   = sel;
                end else if (buf_dv_i) begin
                    for (int k = 0; k < NUM_SEEKERS; k++) begin
                        if (hdr_good(buf_i, pos_q[k])) begin
                            if (cnt_q[k] == LC_W'(LOCK_CNT - 1)) begin
                                cnt_d[k]   = LC_W'(LOCK_CNT);
                                found_d[k] = 1'b1;
                            end else if (cnt_q[k] != LC_W'(LOCK_CNT)) begin
                                cnt_d[k] = cnt_q[k] + 1'b1;
                            end
                        end else begin
                            cnt_d[k] = '0;
                            if (pos_q[k] == 7'((k + 1) * S - 1)) begin
                                pos_d[k] = 7'(k * S);
                            end else begin
                                pos_d[k] = pos_q[k] + 7'd1;
                            end
                        end
                    end
                end
            end
            LOCKED: begin
                // Resync and a bad-count loss on the same edge are one event.
                if (resync_i || (buf_dv_i && bad_n == BD_W'(UNLOCK_CNT))) begin
                    state_d     = SEARCH;
                    locked_d    = 1'b0;
                    lock_lost_d = 1'b1;
                    restart     = 1'b1;
                end else if (buf_dv_i) begin
                    // The beat closing the window is counted, then both clear.
                    if (beat_n == BT_W'(UNLOCK_WIN)) begin
                        beat_d = '0;
                        bad_d  = '0;
                    end else begin
                        beat_d = beat_n;
                        bad_d  = bad_n;
                    end
                end
            end
            default: state_d = SEARCH;
        endcase

        if (restart) begin
            beat_d = '0;
            bad_d  = '0;
            for (int k = 0; k < NUM_SEEKERS; k++) begin
                pos_d[k]   = 7'(k * S);
                cnt_d[k]   = '0;
                found_d[k] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q     <= SEARCH;
            locked_q    <= 1'b0;
            lock_lost_q <= 1'b0;
            offset_q    <= '0;
            winner_q    <= '0;
            last_q      <= WIN_W'(NUM_SEEKERS - 1);
            beat_q      <= '0;
            bad_q       <= '0;
            for (int k = 0; k < NUM_SEEKERS; k++) begin
                pos_q[k]   <= 7'(k * S);
                cnt_q[k]   <= '0;
                found_q[k] <= 1'b0;
            end
        end else begin
            state_q     <= state_d;
            locked_q    <= locked_d;
            lock_lost_q <= lock_lost_d;
            offset_q    <= offset_d;
            winner_q    <= winner_d;
            last_q      <= last_d;
            beat_q      <= beat_d;
            bad_q       <= bad_d;
            for (int k = 0; k < NUM_SEEKERS; k++) begin
                pos_q[k]   <= pos_d[k];
                cnt_q[k]   <= cnt_d[k];
                found_q[k] <= found_d[k];
            end
        end
    end

    assign locked_o    = locked_q;
    assign offset_o    = offset_q;
    assign lock_lost_o = lock_lost_q;
    assign winner_o    = winner_q;
    assign state_o     = (state_q == LOCKED);

endmodule

// File: tb/tb_sync_seeker_rr.sv
// Bench for sync_seeker_rr. The driver builds a static header pattern per
// search, predicts the lock edge from how far each seeker must walk, and
// predicts losses from per-window bad-header tallies. Expected lock / loss
// events go into exp_q; the negedge monitor pops and compares them.
module tb_sync_seeker_rr;
  localparam int FRAME_W    = 66;
  localparam int BUF_W      = 194;
  localparam int NS         = 2;
  localparam int LOCK_CNT   = 4;
  localparam int UNLOCK_CNT = 3;
  localparam int UNLOCK_WIN = 8;
  localparam int S          = FRAME_W / NS;
  localparam int EW         = 41;  // {kind, offset[6:0], winner, cycle[31:0]}

  // ---------------- clock / reset / DUT ----------------
  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [BUF_W-1:0] buf_v = '0;
  logic             dv = 1'b0;
  logic             rs = 1'b0;
  logic             locked, lost, state_dbg;
  logic [6:0]       off;
  logic [0:0]       win;

  sync_seeker_rr #(
    .FRAME_W(FRAME_W), .BUF_W(BUF_W), .NUM_SEEKERS(NS),
    .LOCK_CNT(LOCK_CNT), .UNLOCK_CNT(UNLOCK_CNT), .UNLOCK_WIN(UNLOCK_WIN)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .buf_i(buf_v), .buf_dv_i(dv), .resync_i(rs),
    .locked_o(locked), .offset_o(off), .lock_lost_o(lost), .winner_o(win),
    .state_o(state_dbg)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int               checks = 0;
  int               errors = 0;
  logic [EW-1:0]    exp_q[$];
  bit               bad_plan[$];
  logic [BUF_W-1:0] pat;
  int               g[NS];
  int               last_w, lock_off, lock_w, lk_n;
  int               win_bad[int];
  logic             locked_prev = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_event(input bit kind);
    logic [EW-1:0] e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_event: kind %0d offset %0d winner %0d, none expected (cycle %0d)",
               kind, off, win, cyc);
    end else begin
      e = exp_q.pop_front();
      check("event_kind", kind, e[40]);
      check("event_cycle", cyc, e[31:0]);
      check("offset_o", off, e[39:33]);
      check("winner_o", win, e[32]);
      if (kind) check("locked_o_after_loss", locked, 0);
    end
  endtask

  // Monitor: a rising locked_o or any lock_lost_o high is an event.
  always @(negedge clk) begin
    if (locked === 1'b1 && locked_prev !== 1'b1) check_event(1'b0);
    if (lost === 1'b1) check_event(1'b1);
    locked_prev = locked;
  end

  // ---------------- driver tasks ----------------
  task automatic step(input bit d, input logic [BUF_W-1:0] b, input bit r, input bit rn);
    dv    = d;
    buf_v = b;
    rs    = r;
    rst_n = rn;
    @(posedge clk);
    #1;
  endtask

  // Pattern with good headers exactly at g0/g1 (-1 = none in that slice),
  // plus optionally random good headers above each seeker's first good one.
  task automatic make_pat(input int g0, input int g1, input bit extras);
    bit good[FRAME_W];
    g[0] = g0;
    g[1] = g1;
    for (int p = 0; p < FRAME_W; p++) good[p] = 1'b0;
    for (int k = 0; k < NS; k++) begin
      if (g[k] >= 0) begin
        good[g[k]] = 1'b1;
        if (extras)
          for (int p = g[k] + 1; p < (k + 1) * S; p++) good[p] = ($urandom_range(1) == 1);
      end
    end
    for (int i = 0; i < BUF_W; i++) pat[i] = ($urandom_range(1) == 1);
    for (int p = 0; p < FRAME_W; p++) pat[p + 1] = pat[p] ^ good[p];
  endtask

  // mode 0: continuous beats, 1: 0/1 toggle, 2: random beats.
  // A seeker starting at its base finds g after (g-base) bad beats plus
  // LOCK_CNT good ones; lock shows one edge after the earliest find.
  task automatic search_phase(input int mode, input int rs_at);
    int t[NS];
    int tmin, w, beats, i;
    bit d, r;
    tmin = 1 << 30;
    for (int k = 0; k < NS; k++) begin
      t[k] = (g[k] >= 0) ? g[k] - k * S + LOCK_CNT : (1 << 30);
      if (t[k] < tmin) tmin = t[k];
    end
    w = 0;
    for (int j = NS; j >= 1; j--) if (t[(last_w + j) % NS] == tmin) w = (last_w + j) % NS;
    beats = 0;
    i = 0;
    while (beats < tmin && i < 4000) begin
      r = (i == rs_at);
      case (mode)
        0: d = 1'b1;
        1: d = (i % 2 == 1);
        default: d = ($urandom_range(99) < 70);
      endcase
      if (r) d = 1'b0;
      step(d, pat, r, 1'b1);
      if (r) beats = 0;
      else if (d) beats++;
      i++;
    end
    if (beats < tmin) begin
      checks++;
      errors++;
      $display("FAIL search_budget: beats %0d required %0d", beats, tmin);
    end
    lock_off = g[w];
    lock_w   = w;
    last_w   = w;
    exp_q.push_back({1'b0, 7'(lock_off), 1'(w), 32'(cyc + 1)});
    step($urandom_range(1) == 1, pat, 1'b0, 1'b1);
    lk_n = 0;
    win_bad.delete();
  endtask

  // Locked monitoring: beat n belongs to window (n-1)/UNLOCK_WIN; the
  // UNLOCK_CNT-th bad header of a window (or a resync) loses lock.
  task automatic locked_phase(input int ncyc, input int bad_pct, input int dv_pct,
                              input int rs_cyc, output bit lost_out);
    bit d, b, r;
    int wi;
    logic [BUF_W-1:0] bb;
    lost_out = 1'b0;
    wi = 0;
    for (int c = 0; c < ncyc && !lost_out; c++) begin
      if (bad_plan.size() > 0) begin
        d = 1'b1;
        b = bad_plan.pop_front();
      end else begin
        d = ($urandom_range(99) < dv_pct);
        b = d && ($urandom_range(99) < bad_pct);
      end
      r  = (c == rs_cyc);
      bb = pat;
      if (b) bb[lock_off + 1] = bb[lock_off];
      if (d) begin
        lk_n++;
        if (b) begin
          wi = (lk_n - 1) / UNLOCK_WIN;
          if (!win_bad.exists(wi)) win_bad[wi] = 0;
          win_bad[wi] = win_bad[wi] + 1;
        end
      end
      if (r || (b && win_bad[wi] >= UNLOCK_CNT)) begin
        exp_q.push_back({1'b1, 7'(lock_off), 1'(lock_w), 32'(cyc + 1)});
        lost_out = 1'b1;
      end
      step(d, bb, r, 1'b1);
    end
    bad_plan.delete();
  endtask

  task automatic do_reset();
    step($urandom_range(1) == 1, pat, $urandom_range(1) == 1, 1'b0);
    check("rst_locked_o", locked, 0);
    check("rst_lock_lost_o", lost, 0);
    check("rst_offset_o", off, 0);
    check("rst_winner_o", win, 0);
    check("rst_state", state_dbg, 0);
    last_w = NS - 1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bit lost_b;
    int a, b2, g0, g1;
    pat    = '0;
    last_w = NS - 1;
    step(1'b0, pat, 1'b0, 1'b0);
    do_reset();

    // Only good header at 40: seeker 1 walks 33..40 then locks.
    make_pat(-1, 40, 1'b0);
    search_phase(0, -1);

    // One clean window, three windows with two bad each, then 3 bad in 5.
    repeat (8) bad_plan.push_back(1'b0);
    for (int wdx = 0; wdx < 3; wdx++) begin
      a  = $urandom_range(7);
      b2 = (a + 1 + $urandom_range(6)) % 8;
      for (int j = 0; j < 8; j++) bad_plan.push_back(j == a || j == b2);
    end
    bad_plan.push_back(1'b1); bad_plan.push_back(1'b0); bad_plan.push_back(1'b1);
    bad_plan.push_back(1'b0); bad_plan.push_back(1'b1);
    locked_phase(40, 0, 100, -1, lost_b);

    // Reset mid-search, then a tie at 0/33 resolved round-robin both ways.
    do_reset();
    make_pat(0, 33, 1'b0);
    search_phase(0, -1);
    locked_phase(6, 0, 100, 3, lost_b);
    search_phase(0, -1);
    locked_phase(1, 0, 100, 0, lost_b);

    // Toggling buf_dv_i during search.
    make_pat(-1, 40, 1'b0);
    search_phase(1, -1);

    // Two bad headers then reset while locked: no loss pulse.
    bad_plan.push_back(1'b1); bad_plan.push_back(1'b1);
    bad_plan.push_back(1'b0); bad_plan.push_back(1'b0);
    locked_phase(4, 0, 100, -1, lost_b);
    do_reset();
    make_pat(5, 43, 1'b0);
    search_phase(0, -1);

    // Resync on the same edge as the third bad header.
    bad_plan.push_back(1'b1); bad_plan.push_back(1'b0); bad_plan.push_back(1'b1);
    bad_plan.push_back(1'b0); bad_plan.push_back(1'b1);
    locked_phase(5, 0, 100, 4, lost_b);

    // Randomized rounds.
    repeat (12) begin
      g0 = ($urandom_range(9) == 0) ? -1 : int'($urandom_range(S - 1));
      g1 = (g0 < 0 || $urandom_range(9) != 0) ? S + int'($urandom_range(S - 1)) : -1;
      make_pat(g0, g1, 1'b1);
      search_phase(2, ($urandom_range(2) == 0) ? int'($urandom_range(10)) : -1);
      locked_phase(30, 20, 80, ($urandom_range(4) == 0) ? int'($urandom_range(29)) : -1, lost_b);
      if (!lost_b) begin
        if ($urandom_range(1) == 1) do_reset();
        else locked_phase(1, 0, 100, 0, lost_b);
      end
    end

    repeat (4) step(1'b0, pat, 1'b0, 1'b1);
    check("expected_queue_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
